truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
- Self-contained sequential sweeper/checker for an N-input single-output combinational block.
- On start it drives every input vector 0 to 2^N-1 onto the DUT inputs, holding each vector for a parametrised settle time.
- It samples the DUT output, compares it against a parametrised expected truth table, and reports mismatch count, first failing vector and pass/fail.
- It replaces hand-written exhaustive stimulus blocks in benches and on-board self-test wrappers.

Parameters:
- N, 3, DUT input width; 1..8.
- TRUTH, 8'b1110_1000, expected output table, width 2^N; bit v is the expected output for input vector v. The default is 3-input majority.
- SETTLE, 2, clock cycles each vector is held before sampling; at least 1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a sweep; sampled only in IDLE
- abort  in  1  terminate the sweep in progress
- f_in  in  1  DUT output under test
- stim  out  N  vector driven to the DUT inputs
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at normal completion
- pass  out  1  last completed sweep had zero mismatches
- err_count  out  N+1  mismatches in the current or last sweep
- first_fail_valid  out  1  at least one mismatch recorded
- first_fail_vec  out  N  lowest vector that mismatched

Behaviour:
- Reset (rst_n low, asynchronous, any state): state IDLE; all outputs and internal counters are 0 immediately. Outputs stay 0 until the first clock edge after rst_n rises.
- States: IDLE, SWEEP.
- IDLE, start=1, abort=0 at edge k:
  - Enter SWEEP.
  - busy=1, stim=0, settle_cnt=0.
  - err_count=0, first_fail_valid=0, first_fail_vec=0, pass=0.
- IDLE with start=1 and abort=1: abort wins; stay IDLE with no change.
- SWEEP, per edge:
  - If settle_cnt is less than SETTLE-1, increment settle_cnt.
  - Else this is the sample edge for vector stim. Compare f_in against TRUTH[stim]. On mismatch, err_count increments. On the first mismatch also load first_fail_vec=stim and set first_fail_valid=1. Then settle_cnt=0 and stim=stim+1.
- Last vector (stim=2^N-1) sample edge:
  - Enter IDLE; busy=0; done=1 for exactly one cycle; stim=0.
  - pass = (final err_count == 0), including a mismatch detected on this same edge.
- Latency: done is high in the cycle after edge k + 2^N*SETTLE; 16 cycles for the defaults.
- Each vector is stable on stim for exactly SETTLE cycles. f_in is sampled at the end of the vector's last cycle.
- start while busy: ignored.
- abort=1 in SWEEP (including on a sample edge):
  - Enter IDLE at that edge; that edge's comparison is discarded.
  - busy=0, done stays 0, pass=0, stim=0.
  - err_count, first_fail_valid and first_fail_vec hold their partial values until the next start.
- err_count saturation cannot occur: the maximum is 2^N, which fits in N+1 bits.
- stim wrap: stim never wraps inside a sweep; it is forced to 0 on completion.
- pass, err_count, first_fail_valid and first_fail_vec hold their values in IDLE until the next accepted start or reset.
- Reset mid-sweep: same as the reset rule above; no done pulse.
- f_in is treated as synchronous to clk; no synchroniser is included.

Test Plan (defaults N=3, SETTLE=2, TRUTH=8'hE8 unless noted; f_in driven by a combinational DUT model of stim):
1. Correct majority model; reset, then start for 1 cycle -> stim steps 0..7, each held 2 cycles. done pulses 16 cycles after the start edge; pass=1, err_count=0, first_fail_valid=0.
2. DUT model stuck-at-0 -> err_count=4, first_fail_vec=3, first_fail_valid=1, pass=0.
3. DUT model inverted majority -> err_count=8, first_fail_vec=0, pass=0. Rerun with the correct model -> pass=1 and err_count=0, proving the result clears on start.
4. Abort while stim=4 -> busy=0 next cycle, no done pulse, pass=0, stim=0. Then start with the correct model -> full clean sweep, pass=1.
5. start pulsed again while busy -> ignored, completes at cycle 16. rst_n low at stim=5 -> all outputs 0 asynchronously, before the next clock edge.
6. Parameter override N=4, SETTLE=1, TRUTH=16'h8000 (4-input AND), correct model -> done after 16 cycles, pass=1. Same configuration with an OR model -> err_count=14, first_fail_vec=1.

Source files
------------

// File: rtl/truth_table_sweeper_if.sv
// rtl/truth_table_sweeper_if.sv - control, result and DUT-stimulus bundle of the truth table sweeper
interface truth_table_sweeper_if #(
    parameter int N = 3
);
    logic         start;
    logic         abort;
    logic         f_in;
    logic [N-1:0] stim;
    logic         busy;
    logic         done;
    logic         pass;
    logic [N:0]   err_count;
    logic         first_fail_valid;
    logic [N-1:0] first_fail_vec;

    // Controller / bench side: issues commands, models the DUT, reads results
    modport master (
        output start, abort, f_in,
        input  stim, busy, done, pass, err_count, first_fail_valid, first_fail_vec
    );

    // Sweeper side
    modport slave (
        input  start, abort, f_in,
        output stim, busy, done, pass, err_count, first_fail_valid, first_fail_vec
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - exhaustive input sweeper and truth table checker for an N-input combinational block
module truth_table_sweeper #(
    parameter int                N      = 3,
    parameter logic [(1<<N)-1:0] TRUTH  = 8'b1110_1000,
    parameter int                SETTLE = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    truth_table_sweeper_if.slave   bus
);
    localparam int              CW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE - 1);
    localparam logic [N-1:0]    STIM_LAST   = {N{1'b1}};
    localparam logic [N-1:0]    STIM_ONE    = N'(1);
    localparam logic [N:0]      ERR_ONE     = (N+1)'(1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SWEEP = 1'b1;

    logic [0:0]    state_q,    state_d;
    logic          busy_q,     busy_d;
    logic          done_q,     done_d;
    logic          pass_q,     pass_d;
    logic [N-1:0]  stim_q,     stim_d;
    logic [CW-1:0] settle_q,   settle_d;
    logic [N:0]    err_q,      err_d;
    logic          ff_valid_q, ff_valid_d;
    logic [N-1:0]  ff_vec_q,   ff_vec_d;

    logic          mismatch;

    // The expected bit for the vector currently on stim, compared with what the DUT returns
    always_comb begin
        mismatch = (bus.f_in != TRUTH[stim_q]);
    end

    // Next-state logic: start/abort handling, settle pacing, sampling and result bookkeeping
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        stim_d     = stim_q;
        settle_d   = settle_q;
        err_d      = err_q;
        ff_valid_d = ff_valid_q;
        ff_vec_d   = ff_vec_q;

        if (state_q == S_IDLE) begin
            // abort has priority over start even in IDLE
            if (bus.start && !bus.abort) begin
                state_d    = S_SWEEP;
                busy_d     = 1'b1;
                stim_d     = '0;
                settle_d   = '0;
                err_d      = '0;
                ff_valid_d = 1'b0;
                ff_vec_d   = '0;
                pass_d     = 1'b0;
            end
        end else begin
            if (bus.abort) begin
                // Partial results are kept; the comparison on this edge is dropped
                state_d  = S_IDLE;
                busy_d   = 1'b0;
                pass_d   = 1'b0;
                stim_d   = '0;
                settle_d = '0;
            end else if (settle_q < SETTLE_LAST) begin
                settle_d = settle_q + CW'(1);
            end else begin
                if (mismatch) begin
                    err_d = err_q + ERR_ONE;
                    if (!ff_valid_q) begin
                        ff_valid_d = 1'b1;
                        ff_vec_d   = stim_q;
                    end
                end
                settle_d = '0;
                if (stim_q == STIM_LAST) begin
                    // pass reflects the count including this final sample
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    stim_d  = '0;
                    pass_d  = (err_d == '0);
                end else begin
                    stim_d = stim_q + STIM_ONE;
                end
            end
        end
    end

    // State and result registers; everything clears asynchronously on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            stim_q     <= '0;
            settle_q   <= '0;
            err_q      <= '0;
            ff_valid_q <= 1'b0;
            ff_vec_q   <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            stim_q     <= stim_d;
            settle_q   <= settle_d;
            err_q      <= err_d;
            ff_valid_q <= ff_valid_d;
            ff_vec_q   <= ff_vec_d;
        end
    end

    assign bus.stim             = stim_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.pass             = pass_q;
    assign bus.err_count        = err_q;
    assign bus.first_fail_valid = ff_valid_q;
    assign bus.first_fail_vec   = ff_vec_q;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - randomized self-checking bench for truth_table_sweeper
module tb_truth_table_sweeper;
    logic clk = 1'b0;
    logic rst_n;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  act_a = 8'hE8;
    logic [15:0] act_b = 16'h8000;

    truth_table_sweeper_if #(.N(3)) if_a ();
    truth_table_sweeper_if #(.N(4)) if_b ();

    truth_table_sweeper #(.N(3), .TRUTH(8'hE8), .SETTLE(2)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a)
    );

    truth_table_sweeper #(.N(4), .TRUTH(16'h8000), .SETTLE(1)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b)
    );

    // DUT models: any truth table, looked up from the current stimulus
    assign if_a.f_in = act_a[if_a.stim];
    assign if_b.f_in = act_b[if_b.stim];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int lowest(input logic [15:0] d);
        for (int i = 0; i < 16; i++) if (d[i]) return i;
        return 0;
    endfunction

    function automatic logic [31:0] outs_a();
        return {if_a.busy, if_a.done, if_a.pass, if_a.stim, if_a.err_count,
                if_a.first_fail_valid, if_a.first_fail_vec};
    endfunction

    function automatic logic [31:0] outs_b();
        return {if_b.busy, if_b.done, if_b.pass, if_b.stim, if_b.err_count,
                if_b.first_fail_valid, if_b.first_fail_vec};
    endfunction

    // Full sweep on instance A (8 vectors x 2 cycles); optionally pokes start mid-sweep
    task automatic run_a(input logic [7:0] tbl, input bit poke_start);
        logic [7:0] diff;
        int exp_err;
        diff    = tbl ^ 8'hE8;
        exp_err = $countones(diff);
        act_a   = tbl;
        @(negedge clk);
        if_a.start = 1'b1;
        @(negedge clk);
        if_a.start = 1'b0;
        for (int j = 0; j < 16; j++) begin
            check("a_walk", {if_a.busy, if_a.done, if_a.stim}, {1'b1, 1'b0, 3'(j / 2)});
            if_a.start = poke_start && (j == 3);
            @(negedge clk);
        end
        check("a_done", {if_a.busy, if_a.done, if_a.stim}, {1'b0, 1'b1, 3'd0});
        check("a_err", 32'(if_a.err_count), 32'(exp_err));
        check("a_pass", 32'(if_a.pass), 32'(exp_err == 0));
        check("a_ffv", 32'(if_a.first_fail_valid), 32'(exp_err != 0));
        check("a_ffvec", 32'(if_a.first_fail_vec), 32'(lowest({8'h00, diff})));
        @(negedge clk);
        check("a_done_pulse", 32'(if_a.done), 32'd0);
    endtask

    // Start on A and abort after j cycles; the partial count covers vectors sampled so far
    task automatic abort_a(input logic [7:0] tbl, input int j_ab);
        logic [7:0] diff;
        logic [7:0] mask;
        diff  = tbl ^ 8'hE8;
        mask  = 8'((1 << (j_ab / 2)) - 1);
        diff  = diff & mask;
        act_a = tbl;
        @(negedge clk);
        if_a.start = 1'b1;
        @(negedge clk);
        if_a.start = 1'b0;
        for (int j = 0; j < j_ab; j++) @(negedge clk);
        check("ab_stim", 32'(if_a.stim), 32'(j_ab / 2));
        if_a.abort = 1'b1;
        @(negedge clk);
        if_a.abort = 1'b0;
        check("ab_ctrl", {if_a.busy, if_a.done, if_a.pass, if_a.stim}, 6'd0);
        check("ab_err", 32'(if_a.err_count), 32'($countones(diff)));
        check("ab_ffv", 32'(if_a.first_fail_valid), 32'(diff != 0));
        check("ab_ffvec", 32'(if_a.first_fail_vec), 32'(lowest({8'h00, diff})));
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check("ab_nodone", {if_a.busy, if_a.done}, 2'b00);
        end
    endtask

    // Full sweep on instance B (16 vectors x 1 cycle)
    task automatic run_b(input logic [15:0] tbl);
        logic [15:0] diff;
        int exp_err;
        diff    = tbl ^ 16'h8000;
        exp_err = $countones(diff);
        act_b   = tbl;
        @(negedge clk);
        if_b.start = 1'b1;
        @(negedge clk);
        if_b.start = 1'b0;
        for (int j = 0; j < 16; j++) begin
            check("b_walk", {if_b.busy, if_b.done, if_b.stim}, {1'b1, 1'b0, 4'(j)});
            @(negedge clk);
        end
        check("b_done", {if_b.busy, if_b.done, if_b.stim}, {1'b0, 1'b1, 4'd0});
        check("b_err", 32'(if_b.err_count), 32'(exp_err));
        check("b_pass", 32'(if_b.pass), 32'(exp_err == 0));
        check("b_ffv", 32'(if_b.first_fail_valid), 32'(exp_err != 0));
        check("b_ffvec", 32'(if_b.first_fail_vec), 32'(lowest(diff)));
    endtask

    initial begin
        logic [31:0] held;
        rst_n = 1'b0;
        if_a.start = 1'b0; if_a.abort = 1'b0;
        if_b.start = 1'b0; if_b.abort = 1'b0;
        #1;
        check("reset_a", outs_a(), 32'd0);
        check("reset_b", outs_b(), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_a(8'hE8, 1'b0);            // correct majority
        run_a(8'h00, 1'b0);            // stuck-at-0: 4 errors, first at 3
        run_a(8'h17, 1'b0);            // inverted: 8 errors, first at 0
        run_a(8'hE8, 1'b0);            // results clear on start
        abort_a(8'h00, 8);             // abort while stim=4
        run_a(8'hE8, 1'b0);
        run_a(8'hE8, 1'b1);            // start during sweep is ignored

        // start together with abort in IDLE: nothing happens, results hold
        run_a(8'h00, 1'b0);
        held = outs_a();
        @(negedge clk);
        if_a.start = 1'b1; if_a.abort = 1'b1;
        @(negedge clk);
        if_a.start = 1'b0; if_a.abort = 1'b0;
        check("idle_abort_wins", outs_a(), held);

        // Asynchronous reset mid-sweep at stim=5
        act_a = 8'h00;
        @(negedge clk);
        if_a.start = 1'b1;
        @(negedge clk);
        if_a.start = 1'b0;
        for (int j = 0; j < 10; j++) @(negedge clk);
        check("rst_pre_stim", 32'(if_a.stim), 32'd5);
        rst_n = 1'b0;
        #1;
        check("rst_async", outs_a(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_after", outs_a(), 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_a(8'($urandom), 1'b0);
            abort_a(8'($urandom), int'($urandom_range(0, 15)));
        end

        run_b(16'h8000);               // 4-input AND, correct
        run_b(16'hFFFE);               // OR model: 14 errors, first at 1
        for (int i = 0; i < 3; i++) run_b(16'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
